instr_mem_sync: RTL

Parametrised, synchronous-read instruction memory for the pipelined RISC-V core, sitting between the IF-stage PC register and the IF/ID pipeline register. It replaces the combinational ROM with a one-cycle registered fetch path. Adds pipeline stall and flush handling, misaligned and out-of-range fault detection, and a word-wide program-load port with a RUN/LOAD mode state machine, so the bench or a boot loader can write code at run time.

---
 rtl/instr_mem_sync_if.sv | 39 +++
 rtl/instr_mem_sync.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync_if.sv
// Fetch / program-load bus between the IF stage (or boot loader) and the
// synchronous instruction memory. The memory takes the slave modport.
interface instr_mem_sync_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  // fetch request side
  logic            req_valid;
  logic [31:0]     req_addr;
  logic            stall;
  logic            flush;

  // program-load side
  logic            ld_mode;
  logic            ld_en;
  logic [31:0]     ld_addr;
  logic [XLEN-1:0] ld_data;

  // response / status side
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_instr;
  logic            rsp_fault;
  logic            load_busy;
  logic [CW-1:0]   ld_count;

  modport master (
    output req_valid, req_addr, stall, flush,
    output ld_mode, ld_en, ld_addr, ld_data,
    input  rsp_valid, rsp_instr, rsp_fault, load_busy, ld_count
  );

  modport slave (
    input  req_valid, req_addr, stall, flush,
    input  ld_mode, ld_en, ld_addr, ld_data,
    output rsp_valid, rsp_instr, rsp_fault, load_busy, ld_count
  );
endinterface

// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory with a one-cycle registered fetch
// path, stall/flush handling, address fault detection and a RUN/LOAD mode
// machine that lets a loader write program words at run time.
module instr_mem_sync #(
  parameter int              DEPTH     = 1024,
  parameter int              XLEN      = 32,
  parameter string           INIT_FILE = "",
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
  input  logic             clk,
  input  logic             rst,
  instr_mem_sync_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // mode machine encoding
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  // A byte address faults when it is not word aligned or when any bit above
  // the word-index field is set.
  function automatic logic addr_fault(input logic [31:0] a);
    logic w_misalign;
    logic w_out_of_range;
    w_misalign     = (a[1:0] != 2'b00);
    w_out_of_range = ((a >> (AW + 2)) != 32'd0);
    return w_misalign | w_out_of_range;
  endfunction

  // Word index taken from the byte address (bits above the index are
  // covered by addr_fault).
  function automatic logic [AW-1:0] word_index(input logic [31:0] a);
    return AW'(a >> 2);
  endfunction

  logic [XLEN-1:0] r_mem [DEPTH];

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic            r_rsp_valid;
  logic            w_rsp_valid_nxt;
  logic [XLEN-1:0] r_rsp_instr;
  logic [XLEN-1:0] w_rsp_instr_nxt;
  logic            r_rsp_fault;
  logic            w_rsp_fault_nxt;
  logic [CW-1:0]   r_ld_count;
  logic [CW-1:0]   w_ld_count_nxt;

  logic [AW-1:0]   w_fetch_idx;
  logic            w_fetch_fault;
  logic [XLEN-1:0] w_mem_word;
  logic [AW-1:0]   w_ld_idx;
  logic            w_ld_fault;
  logic            w_ld_wr;
  logic            w_count_full;

  assign w_fetch_idx   = word_index(bus.req_addr);
  assign w_fetch_fault = addr_fault(bus.req_addr);
  assign w_mem_word    = r_mem[w_fetch_idx];
  assign w_ld_idx      = word_index(bus.ld_addr);
  assign w_ld_fault    = addr_fault(bus.ld_addr);
  // Writes only land while already in LOAD, so the entry edge never writes
  // and fetch and write never touch the array on the same edge.
  assign w_ld_wr       = (r_state == ST_LOAD) && bus.ld_en && !w_ld_fault;
  assign w_count_full  = (r_ld_count == CW'(DEPTH));

  // Mode transitions follow ld_mode as sampled at each edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (bus.ld_mode) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (!bus.ld_mode) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Load-session word counter: cleared on LOAD entry, saturates at DEPTH,
  // and keeps its value after returning to RUN.
  always_comb begin
    w_ld_count_nxt = r_ld_count;
    if (r_state == ST_RUN) begin
      if (bus.ld_mode) begin
        w_ld_count_nxt = {CW{1'b0}};
      end else begin
        w_ld_count_nxt = r_ld_count;
      end
    end else begin
      if (w_ld_wr && !w_count_full) begin
        w_ld_count_nxt = r_ld_count + CW'(1);
      end else begin
        w_ld_count_nxt = r_ld_count;
      end
    end
  end

  // Next fetch response: LOAD forces a bubble, otherwise flush > stall > req.
  always_comb begin
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_instr_nxt = r_rsp_instr;
    w_rsp_fault_nxt = r_rsp_fault;
    if (r_state == ST_LOAD) begin
      w_rsp_valid_nxt = 1'b0;
      w_rsp_instr_nxt = NOP_INSTR;
      w_rsp_fault_nxt = 1'b0;
    end else if (bus.flush) begin
      w_rsp_valid_nxt = 1'b0;
      w_rsp_instr_nxt = NOP_INSTR;
      w_rsp_fault_nxt = 1'b0;
    end else if (bus.stall) begin
      w_rsp_valid_nxt = r_rsp_valid;
      w_rsp_instr_nxt = r_rsp_instr;
      w_rsp_fault_nxt = r_rsp_fault;
    end else if (bus.req_valid) begin
      if (w_fetch_fault) begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_instr_nxt = NOP_INSTR;
        w_rsp_fault_nxt = 1'b1;
      end else begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_instr_nxt = w_mem_word;
        w_rsp_fault_nxt = 1'b0;
      end
    end else begin
      w_rsp_valid_nxt = 1'b0;
      w_rsp_instr_nxt = NOP_INSTR;
      w_rsp_fault_nxt = 1'b0;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_ld_count  <= {CW{1'b0}};
      r_rsp_valid <= 1'b0;
      r_rsp_instr <= NOP_INSTR;
      r_rsp_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ld_count  <= w_ld_count_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_instr <= w_rsp_instr_nxt;
      r_rsp_fault <= w_rsp_fault_nxt;
    end
  end

  // Program-load write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_ld_wr) begin
      r_mem[w_ld_idx] <= bus.ld_data;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_instr = r_rsp_instr;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.load_busy = (r_state == ST_LOAD);
  assign bus.ld_count  = r_ld_count;

endmodule
